// File: rtl/alu_issue_arbiter.sv
// Two-requester round-robin issue arbiter in front of a multi-cycle ALU.
// It holds one operation at a time, sequences the ALU reset/start, and returns the result or a timeout error.
module alu_issue_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][5:0]  req_inst_num,
  input  logic [1:0][31:0] req_const16_x,
  input  logic [1:0][4:0]  req_shift5,
  input  logic [1:0][31:0] req_rs,
  input  logic [1:0][31:0] req_rt,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [31:0]      resp_data,
  output logic             resp_err,
  output logic             alu_reset,
  output logic [5:0]       alu_inst_num,
  output logic [31:0]      alu_const16_x,
  output logic [4:0]       alu_shift5,
  output logic [31:0]      alu_rs,
  output logic [31:0]      alu_rt,
  input  logic [31:0]      alu_out,
  input  logic             alu_completed
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last;
  logic               r_id;
  logic [1:0]         r_launch_cnt;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [31:0]        r_resp_data;
  logic               r_resp_err;
  logic [5:0]         r_inst_num;
  logic [31:0]        r_const16_x;
  logic [4:0]         r_shift5;
  logic [31:0]        r_rs;
  logic [31:0]        r_rt;

  logic               w_grant_vld;
  logic               w_grant_id;
  logic               w_accept;
  logic               w_wait_last;
  logic               w_done;
  logic               w_tmo;

  // When both request, the one not served last wins; a lone requester always wins.
  assign w_grant_vld = |req_valid;
  assign w_grant_id  = req_valid[1] & (~req_valid[0] | ~r_last);
  assign w_accept    = (r_state == S_IDLE) & w_grant_vld;

  assign w_wait_last = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
  assign w_done      = (r_state == S_WAIT) & alu_completed;
  assign w_tmo       = (r_state == S_WAIT) & ~alu_completed & w_wait_last;

  always_comb begin
    w_next     = r_state;
    alu_reset  = 1'b1;
    resp_valid = 1'b0;
    req_ready  = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_grant_vld) begin
          req_ready[w_grant_id] = 1'b1;
          w_next                = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (r_launch_cnt == 2'd1) w_next = S_WAIT;
      end
      S_WAIT: begin
        alu_reset = 1'b0;
        if (alu_completed || w_wait_last) w_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last       <= 1'b1;
      r_launch_cnt <= 2'd0;
      r_wait_cnt   <= '0;
    end else begin
      r_state      <= w_next;
      if (w_accept) r_last <= w_grant_id;
      r_launch_cnt <= (r_state == S_LAUNCH) ? r_launch_cnt + 2'd1 : 2'd0;
      r_wait_cnt   <= (r_state == S_WAIT) ? r_wait_cnt + CNT_W'(1) : '0;
    end
  end

  // Operands are captured only on accept, so they stay put until the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_id        <= 1'b0;
      r_inst_num  <= '0;
      r_const16_x <= '0;
      r_shift5    <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
    end else if (w_accept) begin
      r_id        <= w_grant_id;
      r_inst_num  <= req_inst_num[w_grant_id];
      r_const16_x <= req_const16_x[w_grant_id];
      r_shift5    <= req_shift5[w_grant_id];
      r_rs        <= req_rs[w_grant_id];
      r_rt        <= req_rt[w_grant_id];
    end
  end

  // Completion takes priority over a timeout landing in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else if (w_done) begin
      r_resp_data <= alu_out;
      r_resp_err  <= 1'b0;
    end else if (w_tmo) begin
      r_resp_data <= '0;
      r_resp_err  <= 1'b1;
    end
  end

  assign resp_id       = r_id;
  assign resp_data     = r_resp_data;
  assign resp_err      = r_resp_err;
  assign alu_inst_num  = r_inst_num;
  assign alu_const16_x = r_const16_x;
  assign alu_shift5    = r_shift5;
  assign alu_rs        = r_rs;
  assign alu_rt        = r_rt;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a round-robin / ALU reference model with a latency-programmable ALU stub.
module tb_alu_issue_arbiter;

  localparam int TMO = 8;
  localparam logic [5:0] OP_SLL  = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd9;
  localparam logic [5:0] OP_MULT = 6'd24;
  localparam logic [5:0] OP_DIV  = 6'd26;
  localparam logic [5:0] OP_SUB  = 6'd34;
  localparam logic [5:0] OP_AND  = 6'd36;
  localparam logic [5:0] OP_XOR  = 6'd38;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][5:0]  req_inst_num;
  logic [1:0][31:0] req_const16_x;
  logic [1:0][4:0]  req_shift5;
  logic [1:0][31:0] req_rs;
  logic [1:0][31:0] req_rt;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [31:0]      resp_data;
  logic             resp_err;
  logic             alu_reset;
  logic [5:0]       alu_inst_num;
  logic [31:0]      alu_const16_x;
  logic [4:0]       alu_shift5;
  logic [31:0]      alu_rs;
  logic [31:0]      alu_rt;
  logic [31:0]      alu_out;
  logic             alu_completed;

  int n_checks = 0;
  int n_err    = 0;
  int stub_lat = -1;
  int stub_cnt = 0;

  alu_issue_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_inst_num(req_inst_num), .req_const16_x(req_const16_x), .req_shift5(req_shift5),
    .req_rs(req_rs), .req_rt(req_rt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err),
    .alu_reset(alu_reset), .alu_inst_num(alu_inst_num), .alu_const16_x(alu_const16_x),
    .alu_shift5(alu_shift5), .alu_rs(alu_rs), .alu_rt(alu_rt),
    .alu_out(alu_out), .alu_completed(alu_completed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] c,
                                          input logic [4:0] sh, input logic [31:0] rs,
                                          input logic [31:0] rt);
    case (op)
      OP_SLL:  return rt << sh;
      OP_ADDI: return rs + c;
      OP_MULT: return rs * rt;
      OP_DIV:  return (rt == 0) ? 32'd0 : rs / rt;
      OP_SUB:  return rs - rt;
      OP_AND:  return rs & rt;
      OP_XOR:  return rs ^ rt;
      default: return rs + rt;
    endcase
  endfunction

  // ALU stub: counts cycles with its reset low, completes after stub_lat cycles (never if negative).
  always @(posedge clk) begin
    if (alu_reset) stub_cnt <= 0;
    else           stub_cnt <= stub_cnt + 1;
  end
  assign alu_completed = !alu_reset && (stub_lat >= 0) && (stub_cnt == stub_lat);
  assign alu_out = alu_completed ? ref_alu(alu_inst_num, alu_const16_x, alu_shift5, alu_rs, alu_rt)
                                 : 32'hdeadbeef;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [5:0] op, input logic [31:0] c,
                          input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt);
    req_inst_num[p]  = op;
    req_const16_x[p] = c;
    req_shift5[p]    = sh;
    req_rs[p]        = rs;
    req_rt[p]        = rt;
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge with the DUT idle again.
  task automatic do_op(input logic [1:0] vmask, input int exp_port, input int lat, input int hold,
                       input logic [31:0] exp_data, input logic exp_err, input bit noise,
                       input string name);
    int k;
    int exp_l;
    int other;
    bit busy_ok;
    bit stab_ok;
    logic [5:0]  e_op;
    logic [31:0] e_c;
    logic [4:0]  e_sh;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    other    = 1 - exp_port;
    e_op     = req_inst_num[exp_port];
    e_c      = req_const16_x[exp_port];
    e_sh     = req_shift5[exp_port];
    e_rs     = req_rs[exp_port];
    e_rt     = req_rt[exp_port];
    stub_lat = lat;
    req_valid = vmask;
    #1;
    chk({name, " req_ready"}, 32'(req_ready), 32'(1) << exp_port);
    @(negedge clk);
    req_valid[exp_port] = 1'b0;
    k = 0;
    busy_ok = 1'b1;
    #1;
    while (!resp_valid && k < 60) begin
      if (req_ready !== 2'b00) busy_ok = 1'b0;
      @(negedge clk);
      if (noise) req_valid[other] = 1'($urandom_range(0, 1));
      #1;
      k++;
    end
    if (noise) req_valid[other] = 1'b0;
    exp_l = exp_err ? TMO + 2 : 3 + lat;
    chk({name, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({name, " latency"}, 32'(k), 32'(exp_l));
    chk({name, " resp_id"}, 32'(resp_id), 32'(exp_port));
    chk({name, " resp_data"}, resp_data, exp_data);
    chk({name, " resp_err"}, 32'(resp_err), 32'(exp_err));
    chk({name, " alu_reset in RESP"}, 32'(alu_reset), 32'd1);
    chk({name, " req_ready busy"}, 32'(busy_ok), 32'd1);
    chk({name, " alu_rs"}, alu_rs, e_rs);
    chk({name, " alu_rt"}, alu_rt, e_rt);
    chk({name, " alu_const16_x"}, alu_const16_x, e_c);
    chk({name, " alu_op_sh"}, {21'd0, alu_inst_num, alu_shift5}, {21'd0, e_op, e_sh});
    stab_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      if (resp_valid !== 1'b1 || resp_id !== 1'(exp_port) || resp_data !== exp_data ||
          resp_err !== exp_err || req_ready !== 2'b00 || alu_reset !== 1'b1)
        stab_ok = 1'b0;
    end
    chk({name, " hold stable"}, 32'(stab_ok), 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk({name, " back to idle"}, 32'(resp_valid), 32'd0);
  endtask

  typedef struct {
    int          port;
    logic [5:0]  op;
    logic [31:0] c16;
    logic [4:0]  sh;
    logic [31:0] rs;
    logic [31:0] rt;
    int          lat;
    int          hold;
    logic [31:0] exp_data;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vt[7];

  function automatic vec_t mk(input int port, input logic [5:0] op, input logic [31:0] c16,
                              input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
                              input int lat, input int hold, input logic [31:0] ed,
                              input logic ee, input string name);
    vec_t v;
    v.port = port; v.op = op; v.c16 = c16; v.sh = sh; v.rs = rs; v.rt = rt;
    v.lat = lat; v.hold = hold; v.exp_data = ed; v.exp_err = ee; v.name = name;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          quiet;
    logic [1:0]  mask;
    int          exp_port;
    int          rr_last;
    int          lat;
    logic [5:0]  op;
    logic [31:0] ed;
    logic        ee;
    logic [5:0]  ops[7];

    ops = '{OP_SLL, OP_ADDI, OP_MULT, OP_DIV, OP_SUB, OP_AND, OP_XOR};
    vt[0] = mk(0, OP_ADDI, 32'h0000_00ff, 5'd0, 32'd17, 32'd0, 2, 0, 32'd272, 1'b0, "addi");
    vt[1] = mk(1, OP_MULT, 32'd0, 5'd0, 32'hdab, 32'heae, 1, 5, 32'd13149242, 1'b0, "mult_hold");
    vt[2] = mk(0, OP_SUB, 32'd0, 5'd0, 32'd17, 32'd18, 0, 0, 32'hffff_ffff, 1'b0, "sub_lat0");
    vt[3] = mk(1, OP_SLL, 32'd0, 5'd31, 32'd0, 32'd1, TMO - 1, 1, 32'h8000_0000, 1'b0, "sll_tie");
    vt[4] = mk(0, OP_DIV, 32'd0, 5'd0, 32'd100, 32'd7, TMO, 0, 32'd0, 1'b1, "div_tmo");
    vt[5] = mk(1, OP_XOR, 32'd0, 5'd0, 32'd3, 32'd5, -1, 2, 32'd0, 1'b1, "never_done");
    vt[6] = mk(0, OP_XOR, 32'd0, 5'd0, 32'd3, 32'd5, 4, 0, 32'd6, 1'b0, "xor_after_tmo");

    reset = 1'b0;
    req_valid = 2'b00;
    resp_ready = 1'b0;
    for (int p = 0; p < 2; p++) set_port(p, 6'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    #1;
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset resp_id", 32'(resp_id), 32'd0);
    chk("reset resp_data", resp_data, 32'd0);
    chk("reset alu_reset", 32'(alu_reset), 32'd1);
    chk("reset alu operands", alu_rs | alu_rt | alu_const16_x | {21'd0, alu_inst_num, alu_shift5}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Both requesters valid straight after reset: port 0 first, then alternate.
    set_port(0, OP_SUB, 32'd0, 5'd0, 32'd17, 32'd18);
    set_port(1, OP_XOR, 32'd0, 5'd0, 32'd3, 32'd5);
    do_op(2'b11, 0, 1, 0, 32'hffff_ffff, 1'b0, 1'b0, "rr first");
    do_op(2'b10, 1, 2, 0, 32'd6, 1'b0, 1'b0, "rr second");
    do_op(2'b11, 0, 0, 0, 32'hffff_ffff, 1'b0, 1'b0, "rr again");
    req_valid = 2'b00;

    for (int i = 0; i < 7; i++) begin
      set_port(vt[i].port, vt[i].op, vt[i].c16, vt[i].sh, vt[i].rs, vt[i].rt);
      set_port(1 - vt[i].port, 6'($urandom), $urandom, 5'($urandom), $urandom, $urandom);
      do_op(vt[i].port == 0 ? 2'b01 : 2'b10, vt[i].port, vt[i].lat, vt[i].hold,
            vt[i].exp_data, vt[i].exp_err, 1'b0, vt[i].name);
      req_valid = 2'b00;
    end

    // Reset pulse in the middle of WAIT aborts the operation without a response.
    set_port(0, OP_DIV, 32'd0, 5'd0, 32'h0123_4567, 32'hdab);
    stub_lat = -1;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    #1;
    chk("abort in WAIT alu_reset", 32'(alu_reset), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort alu_reset", 32'(alu_reset), 32'd1);
    chk("abort resp_valid", 32'(resp_valid), 32'd0);
    chk("abort alu_rs cleared", alu_rs, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    stub_lat = 0;
    quiet = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      #1;
      if (resp_valid !== 1'b0 || alu_reset !== 1'b1) quiet = 1'b0;
    end
    chk("abort no late response", 32'(quiet), 32'd1);
    set_port(0, OP_AND, 32'd0, 5'd0, 32'd3, 32'd5);
    do_op(2'b01, 0, 3, 0, 32'd1, 1'b0, 1'b0, "and after abort");

    // Randomized traffic against the round-robin and ALU reference model.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rr_last = 1;
    for (int i = 0; i < 40; i++) begin
      mask = 2'($urandom_range(1, 3));
      if (mask == 2'b11) exp_port = (rr_last == 0) ? 1 : 0;
      else               exp_port = (mask == 2'b01) ? 0 : 1;
      for (int p = 0; p < 2; p++) begin
        op = ops[$urandom_range(0, 6)];
        set_port(p, op, $urandom, 5'($urandom), $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom);
      end
      lat = $urandom_range(0, TMO + 2);
      ee  = (lat >= TMO);
      ed  = ee ? 32'd0 : ref_alu(req_inst_num[exp_port], req_const16_x[exp_port],
                                 req_shift5[exp_port], req_rs[exp_port], req_rt[exp_port]);
      do_op(mask, exp_port, lat, $urandom_range(0, 3), ed, ee, mask != 2'b11, $sformatf("rand%0d", i));
      req_valid = 2'b00;
      rr_last = exp_port;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum WAIT cycles before an operation is aborted.
REQ-002 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  reset: asynchronous, active-low (0 = reset asserted).
REQ-004 SHALL have port req_valid  in  2  per-requester operation request.
REQ-005 SHALL have port req_ready  out  2  per-requester accept; req_valid[i] & req_ready[i] = accept.
REQ-006 SHALL have port req_inst_num  in  2x6  per-requester instruction number.
REQ-007 SHALL have port req_const16_x  in  2x32  per-requester extended immediate.
REQ-008 SHALL have port req_shift5  in  2x5  per-requester shift amount.
REQ-009 SHALL have port req_rs, req_rt  in  2x32 each  per-requester source operands.
REQ-010 SHALL have port resp_valid  out  1  result available.
REQ-011 SHALL have port resp_ready  in  1  result consumed when resp_valid & resp_ready.
REQ-012 SHALL have port resp_id  out  1  index of requester owning the result.
REQ-013 SHALL have port resp_data  out  32  ALU result; 0 on timeout.
REQ-014 SHALL have port resp_err  out  1  1 = operation timed out.
REQ-015 SHALL have port alu_reset  out  1  active-high start/hold control to AluExecElement reset.
REQ-016 SHALL have ports alu_inst_num/alu_const16_x/alu_shift5/alu_rs/alu_rt  out  6/32/5/32/32  registered operands to the ALU.
REQ-017 SHALL have ports alu_out  in  32, alu_completed  in  1  from the ALU.

Function
REQ-018 SHALL implement states IDLE, LAUNCH, WAIT, RESP.
REQ-019 IDLE: alu_reset=1; if any req_valid, SHALL assert req_ready for exactly one granted requester (combinational); all others req_ready=0.
REQ-020 Grant SHALL be round-robin: the requester not granted last wins when both are valid; a single valid requester always wins.
REQ-021 On accept, SHALL latch the granted requester's operands into alu_* registers, record the id, update the last-grant pointer, and enter LAUNCH.
REQ-022 LAUNCH: alu_reset=1 for exactly 2 cycles (2-bit counter), then WAIT.
REQ-023 WAIT: alu_reset=0; alu_completed SHALL be qualified only in WAIT; on alu_completed=1, capture alu_out into resp_data, resp_err=0, enter RESP.
REQ-024 WAIT cycle counter SHALL start at 0 on WAIT entry; on reaching TIMEOUT without completion, resp_data=0, resp_err=1, enter RESP.
REQ-025 Completion and timeout in the same cycle: completion SHALL win.
REQ-026 RESP: resp_valid=1, alu_reset=1; resp_id/resp_data/resp_err SHALL stay stable until resp_ready=1, then IDLE next cycle.
REQ-027 req_ready SHALL be 0 in LAUNCH, WAIT, RESP; one operation outstanding at a time.
REQ-028 alu_* operand outputs SHALL stay constant from accept until the next accept.
REQ-029 Minimum latency accept -> resp_valid SHALL be 3 + N cycles, N = cycles from WAIT entry to alu_completed.
REQ-030 Requests withdrawn (req_valid dropped) before accept SHALL have no effect.

Reset
REQ-031 reset=0 SHALL immediately force: state IDLE, alu_reset=1, resp_valid=0, resp_err=0, resp_id=0, resp_data=0, alu_* operands 0, counters 0, last-grant=1 (port 0 wins first).
REQ-032 Reset mid-operation SHALL abort it with no response; no result from the aborted operation SHALL appear after release.

Verification
REQ-033 Port 0 ADDI: inst_num=9, const16_x=0x00ff, rs=17 -> resp_valid with resp_id=0, resp_data=272, resp_err=0.
REQ-034 Both ports valid after reset: port 0 SUB rs=17 rt=18, port 1 XOR rs=3 rt=5 -> first resp id=0 data=0xffffffff, then id=1 data=6; repeat both valid -> port 0 served first again.
REQ-035 resp_ready held 0 for 5 cycles after resp_valid with MULT rs=0xdab rt=0xeae -> resp_data=13149242 stable, req_ready=0 throughout, IDLE one cycle after resp_ready=1.
REQ-036 TIMEOUT=8, ALU stub never completes -> resp_err=1, resp_data=0 exactly 8 cycles after WAIT entry; alu_reset=1 from RESP onward.
REQ-037 reset=0 pulsed during WAIT of DIV rs=0x1234567 rt=0xdab -> no resp_valid afterwards, alu_reset=1, next port 0 AND rs=3 rt=5 returns 1.
